// File: rtl/rv32i_pkg.sv
// Shared rv32i core types used by the writeback stage.
// Related build option: RV32I_WB_SCOREBOARD_EN (see reg_writeback).
package rv32i;

    typedef enum logic {
        REG_IDLE = 1'b0,
        REG_WE   = 1'b1
    } reg_we_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-response buffer for the writeback stage: synchronous FIFO of wb_entry_t.
// A push while full is taken only together with a pop, so occupancy stays put.
module wb_load_fifo
    import rv32i::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    wb_entry_t      mem_q [DEPTH];
    wb_entry_t      mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// rv32i writeback: merges ALU results and buffered load responses into one registered
// register-file write per cycle. RV32I_WB_SCOREBOARD_EN adds the load busy scoreboard.
module reg_writeback
    import rv32i::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output reg_we_e     we,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    reg_we_e     we_q, we_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic        alu_win, fifo_win, direct_win;
    logic        fifo_push, fifo_full, fifo_empty;
    wb_entry_t   fifo_head, ld_wr;

    assign alu_win    = alu_valid && (alu_rd != REG_ZERO);
    assign fifo_win   = !alu_win && !fifo_empty;
    assign direct_win = !alu_win && fifo_empty && lsu_valid;
    assign ld_wr      = fifo_win ? fifo_head : wb_entry_t'{rd: lsu_rd, data: lsu_data};
    assign lsu_ready  = !fifo_full;
    assign fifo_push  = lsu_valid && lsu_ready && !direct_win;

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry (wb_entry_t'{rd: lsu_rd, data: lsu_data}),
        .pop        (fifo_win),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Loads to x0 are still consumed (popped / not pushed) but never raise we.
    always_comb begin
        we_d      = REG_IDLE;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (alu_win) begin
            we_d      = REG_WE;
            rd_addr_d = alu_rd;
            rd_data_d = alu_data;
        end else if ((fifo_win || direct_win) && (ld_wr.rd != REG_ZERO)) begin
            we_d      = REG_WE;
            rd_addr_d = ld_wr.rd;
            rd_data_d = ld_wr.data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q      <= REG_IDLE;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign we      = we_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

`ifdef RV32I_WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;
    logic        ld_clr;

    assign ld_clr = (fifo_win || direct_win) && (ld_wr.rd != REG_ZERO);

    // Set is applied after clear so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (ld_clr) begin
            busy_d[ld_wr.rd] = 1'b0;
        end
        if (ld_issue && (ld_rd != REG_ZERO)) begin
            busy_d[ld_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = (rs1_addr != REG_ZERO) && busy_q[rs1_addr];
    assign rs2_busy = (rs2_addr != REG_ZERO) && busy_q[rs2_addr];
`else
    logic unused_sb;
    assign unused_sb = ^{ld_issue, ld_rd, rs1_addr, rs2_addr};
    assign rs1_busy  = 1'b0;
    assign rs2_busy  = 1'b0;
`endif

endmodule
